// File: rtl/csa_pkg.sv
// Shared types for the carry-save burst accumulator.
package csa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_OUTPUT  = 2'd3
  } csa_accum_state_t;

endpackage

// File: rtl/csa_3_2.sv
// 3:2 carry-save compressor: bitwise full adders with no carry chain.
// Latency 0 (combinational); no flow control.
module csa_3_2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accum_seq.sv
// Burst accumulator keeping the running sum in carry-save form; result 2 cycles after last operand.
// Backpressure: in_ready drops from RESOLVE until the result is taken; result held until out_ready.
module csa_accum_seq
  import csa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  csa_accum_state_t state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, out_valid_q, busy_q;

  logic [WIDTH-1:0] c_shift;
  logic [WIDTH-1:0] csa_sum;
  logic [WIDTH-1:0] csa_carry;
  logic             accept;

  // Carry vector carries weight 2; dropping its MSB is the mod-2^WIDTH wrap.
  assign c_shift = {c_q[WIDTH-2:0], 1'b0};
  assign accept  = in_valid & in_ready_q;

  csa_3_2 #(
    .WIDTH(WIDTH)
  ) u_csa (
    .a    (s_q),
    .b    (c_shift),
    .c    (in_data),
    .sum  (csa_sum),
    .carry(csa_carry)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          s_d     = csa_sum;
          c_d     = csa_carry;
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = in_last ? ST_RESOLVE : ST_ACCUM;
        end
      end
      ST_RESOLVE: begin
        res_d   = s_q + c_shift;
        state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      c_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == ST_IDLE) || (state_d == ST_ACCUM);
      out_valid_q <= (state_d == ST_OUTPUT);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = res_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_csa_accum_seq.sv
// Directed bench for csa_accum_seq (WIDTH=8, CNT_W=2) with a result scoreboard.
module tb_csa_accum_seq;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             busy;

  int n_assert = 0;
  int n_fail   = 0;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] mdl_sum;
  int               mdl_cnt;

  csa_accum_seq #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Golden model: plain integer sum wrapped to WIDTH, saturating count.
  task automatic model_accept(input logic [WIDTH-1:0] d, input logic last);
    exp_t e;
    mdl_sum = mdl_sum + d;
    if (mdl_cnt < CNT_MAX) mdl_cnt++;
    if (last) begin
      e.sum = mdl_sum;
      e.cnt = CNT_W'(mdl_cnt);
      exp_q.push_back(e);
      mdl_sum = '0;
      mdl_cnt = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    mdl_sum = '0;
    mdl_cnt = 0;
    exp_q.delete();
  endtask

  // Called at a negedge; returns at the negedge after the operand is taken.
  task automatic send(input logic [WIDTH-1:0] d, input logic last);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("send_ready_timeout", 32'(guard < 50), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_accept(d, last);
  endtask

  task automatic get_result(input string tag, input int hold);
    int   guard = 0;
    exp_t e;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_valid_timeout"}, 32'(guard < 50), 32'd1);
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_sum"}, 32'(out_sum), 32'(e.sum));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check({tag, "_sum"}, 32'(out_sum), 32'(e.sum));
    check({tag, "_count"}, 32'(out_count), 32'(e.cnt));
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    mdl_sum = '0;
    mdl_cnt = 0;
    @(negedge clk);
    do_reset();

    // 3+5+7 with latency check: RESOLVE one cycle after the last operand, OUTPUT the next.
    send(8'd3, 1'b0);
    send(8'd5, 1'b0);
    send(8'd7, 1'b1);
    check("lat_n1_valid", 32'(out_valid), 32'd0);
    check("lat_n1_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("lat_n2_valid", 32'(out_valid), 32'd1);
    get_result("b357", 0);

    send(8'hFF, 1'b0);
    send(8'h02, 1'b1);
    get_result("wrap", 0);

    send(8'hAA, 1'b1);
    get_result("stall", 5);

    // Reset mid-burst must discard 10+20.
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    do_reset();
    send(8'd1, 1'b1);
    get_result("after_rst", 0);

    for (int i = 0; i < 5; i++) send(8'd1, i == 4);
    get_result("sat", 0);

    // Back-to-back bursts with in_valid held high throughout.
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'd1;
    in_last = 1'b0;
    @(negedge clk);
    model_accept(8'd1, 1'b0);
    in_data = 8'd2;
    in_last = 1'b1;
    @(negedge clk);
    model_accept(8'd2, 1'b1);
    in_data = 8'd4;
    check("b2b_resolve_in_ready", 32'(in_ready), 32'd0);
    check("b2b_resolve_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("b2b_r1_valid", 32'(out_valid), 32'd1);
    check("b2b_r1_in_ready", 32'(in_ready), 32'd0);
    check("b2b_r1_sum", 32'(out_sum), 32'(e.sum));
    check("b2b_r1_count", 32'(out_count), 32'(e.cnt));
    @(negedge clk);
    check("b2b_idle_valid", 32'(out_valid), 32'd0);
    check("b2b_idle_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    model_accept(8'd4, 1'b1);
    in_valid = 1'b0;
    in_last = 1'b0;
    check("b2b_resolve2_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("b2b_r2_valid", 32'(out_valid), 32'd1);
    check("b2b_r2_sum", 32'(out_sum), 32'(e.sum));
    check("b2b_r2_count", 32'(out_count), 32'(e.cnt));
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_end_valid", 32'(out_valid), 32'd0);
    check("b2b_end_busy", 32'(busy), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_accum_seq.md
CSA_ACCUM_SEQ -- requirements
Module: csa_accum_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the operand-count width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: the operand.
REQ-008 The block SHALL have port in_last, input, 1 bit: the operand offered is the final one of its burst.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a result is available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port out_sum, output, WIDTH bits: the burst sum, modulo 2^WIDTH.
REQ-012 The block SHALL have port out_count, output, CNT_W bits: the number of operands in the burst, saturating.
REQ-013 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 The block SHALL implement the states IDLE, ACCUM, RESOLVE and OUTPUT.
REQ-015 An operand SHALL be accepted in a cycle where in_valid and in_ready are both 1.
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in RESOLVE and OUTPUT.
REQ-017 The block SHALL hold the running sum in redundant form in two registers, s_q and c_q, both WIDTH bits.
REQ-018 On each accepted operand, the block SHALL compute a 3:2 compression of s_q, (c_q<<1) truncated to WIDTH bits, and in_data, and SHALL load s_q with the sum vector and c_q with the carry vector.
REQ-019 The operand accumulation path SHALL contain no carry-propagate adder.
REQ-020 Transitions from IDLE on an accepted operand: to ACCUM if in_last=0; to RESOLVE if in_last=1.
REQ-021 Transitions from ACCUM: to RESOLVE on an accepted operand with in_last=1; otherwise stay in ACCUM, including when in_valid=0.
REQ-022 In RESOLVE, the block SHALL spend exactly one cycle loading the result register with (s_q + (c_q<<1)) mod 2^WIDTH, then move to OUTPUT.
REQ-023 In OUTPUT, out_valid SHALL be 1, and out_sum and out_count SHALL be held stable until out_ready=1.
REQ-024 On the OUTPUT handshake, the block SHALL clear s_q, c_q and the count, and return to IDLE.
REQ-025 Latency: if the last operand is accepted in cycle N, out_valid SHALL first be 1 in cycle N+2.
REQ-026 After a result is consumed in cycle M, the block SHALL next accept an operand no earlier than cycle M+1.
REQ-027 The count SHALL increment on each accepted operand and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-028 A burst with a single operand SHALL produce out_sum equal to that operand and out_count equal to 1.
REQ-029 Sum overflow SHALL wrap silently modulo 2^WIDTH, with no error flag.
REQ-030 out_valid SHALL be 0 in every state other than OUTPUT.

Reset
REQ-031 While rst=1, the block SHALL go to IDLE and clear s_q, c_q, the result register and the count to 0.
REQ-032 The outputs SHALL take their reset values in the cycle after rst is sampled high: in_ready=1, out_valid=0, out_sum=0, out_count=0, busy=0.
REQ-033 Reset asserted mid-burst or during OUTPUT SHALL discard the partial or pending result, and that result SHALL never appear on out_sum.
REQ-034 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-035 A shared package csa_pkg SHALL hold the state enum typedef csa_accum_state_t.
REQ-036 The block SHALL instantiate exactly one csa_3_2 (WIDTH=WIDTH) from the arith library as its compression sub-module.
REQ-037 The final addition and all control logic SHALL be local to csa_accum_seq.

Verification
REQ-038 The bench SHALL cover this case with WIDTH=8: operands 3, 5, 7 (last on 7), out_ready=1 -> out_sum=15 and out_count=3, with out_valid asserted 2 cycles after 7 is accepted.
REQ-039 The bench SHALL cover this case with WIDTH=8: operands 0xFF, 0x02 (last) -> out_sum=0x01 and out_count=2 (wrap).
REQ-040 The bench SHALL cover this case: operand 0xAA with last set, then out_ready held at 0 for 5 cycles -> out_valid=1, out_sum=0xAA stable, in_ready=0 and busy=1 throughout; handshake in cycle 6, then IDLE.
REQ-041 The bench SHALL cover this case: operands 10 and 20 with no last, then rst for 1 cycle, then operand 1 with last -> out_sum=1 and out_count=1.
REQ-042 The bench SHALL cover this case with CNT_W=2: five operands of 1 (last on the fifth) -> out_sum=5 and out_count=3 (saturated).
REQ-043 The bench SHALL cover this case: two back-to-back bursts, {1,2} then {4}, with in_valid held at 1 -> results 3 then 4, with no operand accepted while in_ready=0.
